i2c_target_rx: RTL and testbench

I2C_TARGET_RX -- requirements
Module: i2c_target_rx

---
 rtl/i2c_pkg.sv | 38 +++
 rtl/i2c_line_sync.sv | 48 ++++
 rtl/i2c_target_rx.sv | 149 ++++++++++++++
 tb/tb_i2c_target_rx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C types.
//   t_i2c_rw            : R/W bit of the address byte
//   t_i2c_line_ev       : registered bus events from the line synchronizer
//   t_i2c_target_state  : receive-target FSM states
//   i2c_addr_hit()      : address byte matches our 7-bit address with a write
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic {
    I2C_WRITE = 1'b0,
    I2C_READ  = 1'b1
  } t_i2c_rw;

  typedef struct packed {
    logic start;     // SDA fell while SCL high
    logic stop;      // SDA rose while SCL high
    logic scl_rise;
    logic scl_fall;
    logic sda;       // synced SDA level, aligned with the event bits
  } t_i2c_line_ev;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_WAIT_STOP
  } t_i2c_target_state;

  function automatic logic i2c_addr_hit(input logic [I2C_BYTE_W-1:0] addr_byte,
                                        input logic [I2C_ADDR_W-1:0] own_addr);
    return (addr_byte[7:1] == own_addr) && (t_i2c_rw'(addr_byte[0]) == I2C_WRITE);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers for raw SDA/SCL, one history stage, and registered
// one-cycle START / STOP / SCL edge pulses.
//   i_clk, i_rst : system clock, async active-high reset
//   i_sda, i_scl : raw pin levels
//   o_ev         : registered event pulses plus synced SDA level
// All flops reset to 1 (idle bus level) so reset release never looks like an edge.
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_sda,
  input  logic         i_scl,
  output t_i2c_line_ev o_ev
);

  logic [1:0]   sda_sync_q, scl_sync_q;
  logic         sda_hist_q, scl_hist_q;
  t_i2c_line_ev ev_q, ev_d;

  always_comb begin
    ev_d          = ev_q;
    ev_d.start    = sda_hist_q & ~sda_sync_q[1] & scl_sync_q[1];
    ev_d.stop     = ~sda_hist_q & sda_sync_q[1] & scl_sync_q[1];
    ev_d.scl_rise = ~scl_hist_q & scl_sync_q[1];
    ev_d.scl_fall = scl_hist_q & ~scl_sync_q[1];
    ev_d.sda      = sda_sync_q[1];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sda_sync_q <= 2'b11;
      scl_sync_q <= 2'b11;
      sda_hist_q <= 1'b1;
      scl_hist_q <= 1'b1;
      ev_q       <= '{start: 1'b0, stop: 1'b0, scl_rise: 1'b0, scl_fall: 1'b0, sda: 1'b1};
    end else begin
      sda_sync_q <= {sda_sync_q[0], i_sda};
      scl_sync_q <= {scl_sync_q[0], i_scl};
      sda_hist_q <= sda_sync_q[1];
      scl_hist_q <= scl_sync_q[1];
      ev_q       <= ev_d;
    end
  end

  assign o_ev = ev_q;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: receives an address byte, ACKs a write to
// TARGET_ADDR, then receives data bytes and hands them to a sink.
//   i_clk, i_rst   : system clock, async active-high reset
//   i_sda, i_scl   : raw bus levels (SCL is never driven)
//   o_sda_drive    : 1 = release SDA, 0 = pull SDA low
//   o_data/o_valid : received byte, one-cycle valid pulse
//   i_ready        : sink ready, sampled on the bit-0 rising edge (ACK/NACK)
//   o_start/o_stop : one-cycle pulses per START (incl. repeated) / STOP
//   o_busy         : FSM not idle
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter int                    CLK_FREQ    = 25_000_000,
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h42
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sda,
  input  logic                  i_scl,
  output logic                  o_sda_drive,
  output logic [I2C_BYTE_W-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_start,
  output logic                  o_stop,
  output logic                  o_busy
);

  // Enough system clocks per fast-mode bit to see every synced SCL edge.
  localparam int CLKS_PER_FM_BIT = CLK_FREQ / 400_000;
  always_comb assert (CLKS_PER_FM_BIT >= 16);

  t_i2c_line_ev ev;

  i2c_line_sync u_line_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_sda (i_sda),
    .i_scl (i_scl),
    .o_ev  (ev)
  );

  t_i2c_target_state     state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [I2C_BYTE_W-1:0] shift_q, shift_d, data_q, data_d, byte_w;
  logic                  valid_q, valid_d, start_q, start_d, stop_q, stop_d;
  // arm: ACK owed, waiting for the fall that ends bit 0. drive: ACK on the bus.
  logic                  arm_q, arm_d, drive_q, drive_d;

  assign byte_w = {shift_q[6:0], ev.sda};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    arm_d     = arm_q;
    drive_d   = drive_q;
    valid_d   = 1'b0;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    if (ev.start) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      arm_d     = 1'b0;
      drive_d   = 1'b0;
      start_d   = 1'b1;
    end else if (ev.stop) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      arm_d     = 1'b0;
      drive_d   = 1'b0;
      stop_d    = 1'b1;
    end else begin
      case (state_q)
        ST_ADDR, ST_DATA: begin
          if (ev.scl_rise) begin
            shift_d   = byte_w;
            bit_cnt_d = bit_cnt_q + 3'd1;  // wraps to 0 after bit 0
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ST_ADDR) begin
                if (i2c_addr_hit(byte_w, TARGET_ADDR)) begin
                  state_d = ST_ADDR_ACK;
                  arm_d   = 1'b1;
                end else begin
                  state_d = ST_WAIT_STOP;
                end
              end else if (i_ready) begin
                data_d  = byte_w;
                valid_d = 1'b1;
                state_d = ST_DATA_ACK;
                arm_d   = 1'b1;
              end else begin
                state_d = ST_WAIT_STOP;  // byte dropped, NACK by staying released
              end
            end
          end
        end
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (ev.scl_fall) begin
            if (arm_q) begin
              arm_d   = 1'b0;
              drive_d = 1'b1;
            end else begin
              drive_d   = 1'b0;
              state_d   = ST_DATA;
              bit_cnt_d = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      arm_q     <= 1'b0;
      drive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      arm_q     <= arm_d;
      drive_q   <= drive_d;
    end
  end

  // SDA follows the registered fall pulse directly so the pin changes on the
  // same cycle the synced fall is seen; both terms come from flops only.
  assign o_sda_drive = ~((drive_q & ~ev.scl_fall) | (arm_q & ev.scl_fall));
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_start     = start_q;
  assign o_stop      = stop_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_target_rx.sv
module tb_i2c_target_rx;

  localparam int Q = 8;  // quarter SCL period in system clocks

  logic       i_clk = 1'b0, i_rst = 1'b1, i_ready = 1'b1;
  logic       m_sda = 1'b1, m_scl = 1'b1;
  logic       i_sda, i_scl;
  logic       o_sda_drive, o_valid, o_start, o_stop, o_busy;
  logic [7:0] o_data;

  // wired-AND open-drain bus
  assign i_sda = m_sda & o_sda_drive;
  assign i_scl = m_scl;

  i2c_target_rx #(.CLK_FREQ(25_000_000), .TARGET_ADDR(7'h42)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sda(i_sda), .i_scl(i_scl),
    .o_sda_drive(o_sda_drive), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_start(o_start), .o_stop(o_stop), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // event counters sampled away from the active edge
  int n_valid = 0, n_start = 0, n_stop = 0, n_drv_low = 0, n_data_bad = 0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_valid) n_valid++;
      if (o_start) n_start++;
      if (o_stop) n_stop++;
      if (!o_sda_drive) n_drv_low++;
      if (o_data !== prev_data && !o_valid) n_data_bad++;
    end
    prev_data = o_data;
  end

  // reference model state
  logic [7:0] exp_data = 8'h00;
  logic [7:0] tx_b[4];
  bit         tx_r[4];

  task automatic ticks(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic do_start();
    if (m_scl == 1'b0) begin
      ticks(Q); m_sda = 1'b1; ticks(Q); m_scl = 1'b1; ticks(Q);
    end
    m_sda = 1'b0; ticks(Q); m_scl = 1'b0;
  endtask

  task automatic do_stop();
    ticks(Q); m_sda = 1'b0; ticks(Q); m_scl = 1'b1; ticks(Q); m_sda = 1'b1; ticks(Q);
  endtask

  task automatic clk_bit(input bit b, output bit pin);
    ticks(Q); m_sda = b; ticks(Q); m_scl = 1'b1; ticks(Q); pin = i_sda; ticks(Q); m_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_ack, input string tag);
    bit pin;
    int n;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], pin);
    if (exp_ack) begin
      n = 0;
      while (o_sda_drive && n < 10) begin @(posedge i_clk); #1; n++; end
      chk({tag, "_ack_latency"}, n, 3);
    end
    clk_bit(1'b1, pin);
    chk({tag, "_ack"}, {31'd0, ~pin}, {31'd0, exp_ack});
  endtask

  // one write transaction; expectations derived from the protocol rules only
  task automatic run_txn(input logic [7:0] addr, input int nb);
    int  v0, s0, p0, d0, b0, ev;
    bit  a_ok, alive, k;
    v0 = n_valid; s0 = n_start; p0 = n_stop; d0 = n_drv_low; b0 = n_data_bad;
    a_ok  = (addr[7:1] == 7'h42) && (addr[0] == 1'b0);
    alive = a_ok;
    ev    = 0;
    do_start();
    send_byte(addr, a_ok, "addr");
    for (int i = 0; i < nb; i++) begin
      i_ready = tx_r[i];
      k = alive && tx_r[i];
      send_byte(tx_b[i], k, "data");
      if (k) begin ev++; exp_data = tx_b[i]; end
      else alive = 1'b0;
    end
    chk("busy_before_stop", o_busy, 1);
    do_stop();
    ticks(6);
    chk("valid_count", n_valid - v0, ev);
    chk("start_count", n_start - s0, 1);
    chk("stop_count", n_stop - p0, 1);
    chk("o_data", o_data, exp_data);
    chk("sda_released", o_sda_drive, 1);
    chk("busy_idle", o_busy, 0);
    chk("data_stable", n_data_bad - b0, 0);
    if (!a_ok) chk("never_driven", n_drv_low - d0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int  s0, p0, v0, n;
    bit  pin;
    logic [7:0] b;

    // reset state
    ticks(3);
    chk("rst_sda_drive", o_sda_drive, 1);
    chk("rst_o_data", o_data, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_start", o_start, 0);
    chk("rst_o_stop", o_stop, 0);
    chk("rst_o_busy", o_busy, 0);
    i_rst = 1'b0;
    ticks(8);
    chk("rst_release_no_events", n_start + n_stop, 0);

    // sink not ready: address ACK, data NACK, o_data keeps reset value
    tx_b[0] = 8'h3C; tx_r[0] = 1'b0;
    run_txn(8'h84, 1);
    // two bytes acked, last one visible
    tx_b[0] = 8'h5A; tx_r[0] = 1'b1; tx_b[1] = 8'hA5; tx_r[1] = 1'b1;
    run_txn(8'h84, 2);
    // address mismatch and read request
    tx_b[0] = 8'h77; tx_r[0] = 1'b1;
    run_txn(8'h86, 1);
    run_txn(8'h85, 1);

    // repeated START after 4 data bits
    s0 = n_start; p0 = n_stop; v0 = n_valid;
    do_start();
    send_byte(8'h84, 1'b1, "rs_addr1");
    i_ready = 1'b1;
    b = 8'hF0;
    for (int i = 7; i >= 4; i--) clk_bit(b[i], pin);
    do_start();
    send_byte(8'h84, 1'b1, "rs_addr2");
    send_byte(8'h11, 1'b1, "rs_data");
    exp_data = 8'h11;
    do_stop();
    ticks(6);
    chk("rs_start_count", n_start - s0, 2);
    chk("rs_valid_count", n_valid - v0, 1);
    chk("rs_stop_count", n_stop - p0, 1);
    chk("rs_o_data", o_data, exp_data);

    // reset in the middle of the address ACK
    do_start();
    b = 8'h84;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], pin);
    n = 0;
    while (o_sda_drive && n < 10) begin @(posedge i_clk); #1; n++; end
    chk("midack_driving", o_sda_drive, 0);
    i_rst = 1'b1;
    #1;
    chk("midack_rst_release", o_sda_drive, 1);
    chk("midack_rst_busy", o_busy, 0);
    chk("midack_rst_o_data", o_data, 0);
    exp_data = 8'h00;
    ticks(3);
    s0 = n_start; p0 = n_stop;
    i_rst = 1'b0;
    ticks(6);
    m_sda = 1'b1;
    ticks(Q);
    m_scl = 1'b1;
    ticks(Q);
    chk("post_rst_no_start", n_start - s0, 0);
    chk("post_rst_no_stop", n_stop - p0, 0);
    chk("post_rst_idle", o_busy, 0);

    // randomized transactions
    for (int t = 0; t < 12; t++) begin
      logic [7:0] a;
      int nb;
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h84;
      nb = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) begin
        tx_b[i] = 8'($urandom);
        tx_r[i] = ($urandom_range(0, 4) != 0);
      end
      run_txn(a, nb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
